// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and defaults for the boot image feeder
package boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP
  } state_t;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;
  localparam int         RETRY_W     = 8;

endpackage

// File: rtl/resp_watchdog.sv
// rtl/resp_watchdog.sv - response timeout counter paired with per-byte retry count
module resp_watchdog
  import boot_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               tick,
  input  logic               retry_clr,
  input  logic               retry_inc,
  output logic               expired,
  output logic [RETRY_W-1:0] retry_cnt
);

  logic [19:0] cnt;

  // Counts cycles since the last transmit request; saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 20'd0;
      retry_cnt <= '0;
    end else begin
      if (load)
        cnt <= 20'd0;
      else if (tick && cnt != 20'hF_FFFF)
        cnt <= cnt + 20'd1;
      if (retry_clr)
        retry_cnt <= '0;
      else if (retry_inc)
        retry_cnt <= retry_cnt + 1'b1;
    end
  end

  assign expired = (cnt >= TIMEOUT_CYC);

endmodule

// File: rtl/boot_loader_feeder.sv
// rtl/boot_loader_feeder.sv - streams an image from memory to a serial command port, byte by byte with ACK/retry
module boot_loader_feeder
  import boot_pkg::*;
#(
  parameter logic [7:0]  ACK         = ACK_DEFAULT,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000,
  parameter int          MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num_bytes,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic [7:0]  cmd,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] bytes_acked
);

  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  state_t state, state_nxt;
  logic [15:0] len;
  logic [15:0] acked_inc;
  logic wd_load, wd_tick, retry_clr, retry_inc, expired;
  logic [RETRY_W-1:0] retry_cnt;
  logic accept, zero_done, ack_inc, finish, abort, fail;

  assign acked_inc = bytes_acked + 16'd1;

  resp_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (wd_load),
    .tick      (wd_tick),
    .retry_clr (retry_clr),
    .retry_inc (retry_inc),
    .expired   (expired),
    .retry_cnt (retry_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wd_load   = 1'b0;
    wd_tick   = 1'b0;
    retry_clr = 1'b0;
    retry_inc = 1'b0;
    accept    = 1'b0;
    zero_done = 1'b0;
    ack_inc   = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    fail      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_bytes != 16'd0) begin
            accept    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            zero_done = 1'b1;
          end
        end
      end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: begin
        retry_clr = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        wd_load   = 1'b1;
        state_nxt = S_WAIT_SENT;
      end
      S_WAIT_SENT, S_WAIT_RESP: begin
        // A response wins over both timeout and cmd_sent; it may arrive before cmd_sent.
        wd_tick = 1'b1;
        if (resp_rdy) begin
          if (resp == ACK) begin
            ack_inc = 1'b1;
            if (acked_inc == len) begin
              finish    = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_FETCH;
            end
          end else begin
            fail = 1'b1;
          end
        end else if (expired) begin
          fail = 1'b1;
        end else if (state == S_WAIT_SENT && cmd_sent) begin
          state_nxt = S_WAIT_RESP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (fail) begin
      if (retry_cnt < MAX_R) begin
        retry_inc = 1'b1;
        state_nxt = S_SEND;
      end else begin
        abort     = 1'b1;
        state_nxt = S_IDLE;
      end
    end
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len         <= 16'd0;
      bytes_acked <= 16'd0;
      mem_addr    <= 16'd0;
      mem_rd      <= 1'b0;
      send_cmd    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cmd         <= 8'd0;
    end else begin
      mem_rd   <= (state_nxt == S_FETCH);
      send_cmd <= (state_nxt == S_SEND);
      busy     <= (state_nxt != S_IDLE);
      done     <= finish | zero_done;
      if (accept) begin
        len         <= num_bytes;
        bytes_acked <= 16'd0;
        mem_addr    <= 16'd0;
        err         <= 1'b0;
      end
      if (zero_done) err <= 1'b0;
      if (ack_inc) begin
        bytes_acked <= acked_inc;
        mem_addr    <= acked_inc;
      end
      if (abort) err <= 1'b1;
      if (state == S_LATCH) cmd <= mem_data;
    end
  end

endmodule
